// File: rtl/bf16_adder_arbiter.sv
// Round-robin arbiter sharing one multi-cycle bfloat16 adder between N_REQ requesters.
// Requests are served one at a time; a hung adder is timed out and answered with a NaN error.
module bf16_adder_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 32,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [15:0]           rsp_sum,
    output logic                  rsp_error,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic                  add_start,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    input  logic                  add_done,
    input  logic [15:0]           add_sum,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [15:0] TIMEOUT_NAN = 16'h7FC1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   pick;
    logic              found;
    logic [15:0]       op_a, op_b, sel_a, sel_b;
    logic [15:0]       result;
    logic              err;
    logic [TW-1:0]     timer;
    logic [N_REQ-1:0]  pick_onehot, grant_onehot;
    logic              grant_rsp_ready;
    logic              timed_out;

    // Search starts just after the last served requester so everyone gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!found && ((req_valid >> cand) & 1'b1) != '0) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == pick) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    assign pick_onehot     = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
    assign grant_onehot    = {{(N_REQ-1){1'b0}}, 1'b1} << grant;
    assign grant_rsp_ready = |(rsp_ready & grant_onehot);
    assign timed_out       = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        add_start  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready  = pick_onehot;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                add_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (add_done || timed_out) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid = grant_onehot;
                if (grant_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= ID_W'(N_REQ - 1);
            grant      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            err        <= 1'b0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A result arriving on the timeout cycle still counts as a success.
                    if (add_done) begin
                        result <= add_sum;
                        err    <= 1'b0;
                    end else if (timed_out) begin
                        result <= TIMEOUT_NAN;
                        err    <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (grant_rsp_ready) begin
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_a     = op_a;
    assign add_b     = op_b;
    assign rsp_sum   = (state == RESPOND) ? result : 16'h0000;
    assign rsp_error = (state == RESPOND) ? err : 1'b0;
    assign busy      = (state != IDLE);
    assign grant_id  = grant;

endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// Scoreboard bench for bf16_adder_arbiter: directed requests, a stub adder with
// programmable latency, and a monitor that checks every consumed response.
module tb_bf16_adder_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_sum;
    logic        rsp_error;
    logic [3:0]  rsp_ready;
    logic        add_start;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_done;
    logic [15:0] add_sum;
    logic        busy;
    logic [1:0]  grant_id;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   adder_lat = 1;

    bf16_adder_arbiter #(.N_REQ(4), .TIMEOUT(32)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_error(rsp_error), .rsp_ready(rsp_ready),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_sum(add_sum),
        .busy(busy), .grant_id(grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-computed bfloat16 sums for the operand pairs used below.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {16'h3F80, 16'h4000}: ref_add = 16'h4040;
            {16'h3F80, 16'h3F80}: ref_add = 16'h4000;
            {16'h4000, 16'h4000}: ref_add = 16'h4080;
            {16'h4040, 16'h4000}: ref_add = 16'h40A0;
            {16'h4080, 16'h4080}: ref_add = 16'h4100;
            {16'hBF80, 16'hBF80}: ref_add = 16'hC000;
            default:              ref_add = 16'h1234;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid_mask);
        @(posedge clock);
        #1 req_valid = valid_mask;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [15:0] sum, input logic err);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_accept(input logic [3:0] exp_ready, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (req_ready == 4'b0 && n < 100);
        checkOutput(name, 64'(req_ready), 64'(exp_ready));
    endtask

    // Counts cycles from the accept edge to the first rsp_valid.
    task automatic wait_response(input logic [3:0] next_valid, input int exp_lat, input string name);
        int n;
        @(posedge clock);
        #1 req_valid = next_valid;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (rsp_valid == 4'b0 && n < 100);
        checkOutput(name, 64'(n), 64'(exp_lat));
    endtask

    task automatic check_all_zero(input string name);
        checkOutput(name, {req_ready, rsp_valid, rsp_sum, rsp_error, add_start, add_a, add_b, busy, grant_id},
                    64'd0);
    endtask

    // Stub adder: answers add_start after adder_lat cycles; 0 means it hangs.
    initial begin
        int          lat_now;
        logic [15:0] sum_now;
        add_done = 1'b0;
        add_sum  = 16'h0000;
        forever begin
            @(negedge clock);
            if (add_start === 1'b1 && adder_lat > 0) begin
                lat_now = adder_lat;
                sum_now = ref_add(add_a, add_b);
                repeat (lat_now) @(posedge clock);
                #1 add_done = 1'b1;
                add_sum = sum_now;
                @(posedge clock);
                #1 add_done = 1'b0;
                add_sum = 16'h0000;
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (req_ready != 4'b0)
                    checkOutput("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                if (rsp_valid != 4'b0) begin
                    checkOutput("rsp_valid_onehot", 64'($onehot(rsp_valid)), 64'd1);
                    if ((rsp_valid & rsp_ready) != 4'b0) begin
                        checkOutput("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            checkOutput("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
                            checkOutput("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                            checkOutput("rsp_error", 64'(rsp_error), 64'(e.err));
                        end
                    end
                end else begin
                    checkOutput("idle_rsp_zero", 64'({rsp_sum, rsp_error}), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] order[6];
        logic       spurious;
        int         n;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        reset     = 1'b1;
        req_valid = 4'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 4'b1111;
        @(negedge clock);
        check_all_zero("reset_outputs");
        @(posedge clock);
        #1 reset = 1'b0;

        // 1.0 + 2.0 on requester 0, adder done 3 cycles after start
        $display("[TB] single request");
        set_ops(0, 16'h3F80, 16'h4000);
        adder_lat = 3;
        push_exp(2'd0, 16'h4040, 1'b0);
        applyStimulus(4'b0001);
        wait_accept(4'b0001, "t1_accept");
        wait_response(4'b0000, 5, "t1_latency");
        checkOutput("t1_grant_id", 64'(grant_id), 64'd0);

        // All four requesting with a one-cycle adder: strict rotation
        $display("[TB] round robin");
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        set_ops(0, 16'h3F80, 16'h3F80);
        set_ops(1, 16'h4000, 16'h4000);
        set_ops(2, 16'h4040, 16'h4000);
        set_ops(3, 16'h4080, 16'h4080);
        adder_lat = 1;
        push_exp(2'd0, 16'h4000, 1'b0);
        push_exp(2'd1, 16'h4080, 1'b0);
        push_exp(2'd2, 16'h40A0, 1'b0);
        push_exp(2'd3, 16'h4100, 1'b0);
        push_exp(2'd0, 16'h4000, 1'b0);
        push_exp(2'd1, 16'h4080, 1'b0);
        applyStimulus(4'b1111);
        for (int i = 0; i < 6; i++) begin
            wait_accept(order[i], $sformatf("t2_grant%0d", i));
            wait_response((i == 5) ? 4'b0000 : 4'b1111, 3, $sformatf("t2_latency%0d", i));
        end

        // Hung adder on requester 1
        $display("[TB] timeout");
        adder_lat = 0;
        set_ops(1, 16'h3F80, 16'h4000);
        push_exp(2'd1, 16'h7FC1, 1'b1);
        applyStimulus(4'b0010);
        wait_accept(4'b0010, "t3_accept");
        wait_response(4'b0000, 34, "t3_latency");

        // Response back-pressure on requester 2; other rsp_ready bits must not release it
        $display("[TB] back-pressure");
        adder_lat = 1;
        rsp_ready = 4'b1011;
        set_ops(2, 16'h4080, 16'h4080);
        push_exp(2'd2, 16'h4100, 1'b0);
        applyStimulus(4'b0100);
        wait_accept(4'b0100, "t4_accept");
        wait_response(4'b1111, 3, "t4_latency");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold", {req_ready, rsp_valid, rsp_sum, rsp_error}, {4'b0000, 4'b0100, 16'h4100, 1'b0});
            @(negedge clock);
        end
        checkOutput("t4_still_held", 64'(rsp_valid), 64'(4'b0100));
        @(posedge clock);
        #1 rsp_ready = 4'b1111;
        req_valid = 4'b0000;

        // Adder answers on the very cycle the timeout would fire
        $display("[TB] done on timeout cycle");
        adder_lat = 32;
        set_ops(3, 16'hBF80, 16'hBF80);
        push_exp(2'd3, 16'hC000, 1'b0);
        applyStimulus(4'b1000);
        wait_accept(4'b1000, "t5_accept");
        wait_response(4'b0000, 34, "t5_latency");

        // Reset during WAIT, then a late add_done arrives
        $display("[TB] reset mid-operation");
        adder_lat = 10;
        set_ops(0, 16'h3F80, 16'h4000);
        applyStimulus(4'b0001);
        wait_accept(4'b0001, "t6_accept");
        @(posedge clock);
        #1 req_valid = 4'b0000;
        repeat (3) @(negedge clock);
        checkOutput("t6_busy_before_reset", 64'(busy), 64'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check_all_zero("t6_reset_outputs");
        @(posedge clock);
        #1 reset = 1'b0;
        adder_lat = 1;
        spurious = 1'b0;
        n = 0;
        repeat (15) begin
            @(negedge clock);
            if (add_done) n++;
            spurious = spurious | (|rsp_valid) | busy | (|req_ready);
        end
        checkOutput("t6_late_done_seen", 64'(n), 64'd1);
        checkOutput("t6_no_activity", 64'(spurious), 64'd0);
        push_exp(2'd0, 16'h4040, 1'b0);
        applyStimulus(4'b1111);
        wait_accept(4'b0001, "t6_first_grant");
        wait_response(4'b0000, 3, "t6_latency");

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
